// File: rtl/btn_pkg.sv
// Shared types and default timing for the power-button classifier.
// FSM state encoding plus millisecond-based timing defaults converted
// to clock cycles at the nominal system clock frequency.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HELD,
        LONG,
        WAIT_SECOND,
        SUPPRESS
    } btn_state_e;

    localparam int CLK_FREQ      = 100_000_000;
    localparam int DEBOUNCE_MS   = 20;
    localparam int LONG_PRESS_MS = 3000;
    localparam int DOUBLE_GAP_MS = 300;

    // Milliseconds to clock cycles at CLK_FREQ.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_FREQ / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// Button-side bundle: raw button in, debounced level, hold flag and
// classification pulses out. The classifier uses the slave modport;
// whatever drives the button and consumes the pulses uses master.
interface button_press_classifier_if;

    logic btn_raw;
    logic btn_level;
    logic hold_active;
    logic short_press;
    logic long_press;
    logic double_press;

    modport slave (
        input  btn_raw,
        output btn_level,
        output hold_active,
        output short_press,
        output long_press,
        output double_press
    );

    modport master (
        output btn_raw,
        input  btn_level,
        input  hold_active,
        input  short_press,
        input  long_press,
        input  double_press
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability debouncer. The debounced
// level only changes after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] deb_cnt_q;
    logic [CW-1:0] deb_cnt_d;
    logic          btn_sync;

    assign btn_sync = sync_q[1];

    // Next debounce count and level from the synchronized sample.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        if (btn_sync != level_q) begin
            if (deb_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d   = ~level_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer chain and debounce state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= 2'b00;
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw_i};
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_level_o = level_q;

endmodule

// File: rtl/button_press_classifier.sv
// Power-button classifier: debounces the raw button and turns each press
// into a single-cycle short_press or long_press pulse for the power/mode
// controller. Optional double-press detection is built when the macro
// DOUBLE_PRESS_EN is defined; otherwise double_press is tied low.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = ms_to_cycles(DEBOUNCE_MS),
    parameter int LONG_CYCLES       = ms_to_cycles(LONG_PRESS_MS),
    parameter int DOUBLE_GAP_CYCLES = ms_to_cycles(DOUBLE_GAP_MS)
) (
    input  logic                      clk,
    input  logic                      reset,
    button_press_classifier_if.slave  btn_if
);

    localparam int HW = $clog2(LONG_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || DOUBLE_GAP_CYCLES < 1) begin : g_param_check
        $error("button_press_classifier: illegal timing parameters");
    end

    logic          btn_level;
    btn_state_e    state_q;
    logic [HW-1:0] hold_cnt_q;
    logic          short_q;
    logic          long_q;
    logic          hold_active_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .btn_raw_i   (btn_if.btn_raw),
        .btn_level_o (btn_level)
    );

`ifdef DOUBLE_PRESS_EN
    localparam int GW = $clog2(DOUBLE_GAP_CYCLES + 1);
    logic [GW-1:0] gap_cnt_q;
    logic          double_q;
`endif

    // Press-duration FSM with registered pulses and hold flag. The cycle in
    // which btn_level first reads high counts as held cycle 0, so HELD is
    // entered with hold_cnt already at 1 and long_press lands exactly
    // LONG_CYCLES cycles after the debounced rise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            hold_cnt_q    <= '0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            hold_active_q <= 1'b0;
`ifdef DOUBLE_PRESS_EN
            gap_cnt_q     <= '0;
            double_q      <= 1'b0;
`endif
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef DOUBLE_PRESS_EN
            double_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    hold_cnt_q <= '0;
                    if (btn_level) begin
                        state_q       <= HELD;
                        hold_cnt_q    <= HW'(1);
                        hold_active_q <= 1'b1;
                    end
                end
                HELD: begin
                    // A release on the threshold cycle is still a short press.
                    if (!btn_level) begin
                        hold_active_q <= 1'b0;
`ifdef DOUBLE_PRESS_EN
                        state_q   <= WAIT_SECOND;
                        gap_cnt_q <= '0;
`else
                        short_q   <= 1'b1;
                        state_q   <= IDLE;
`endif
                    end else if (hold_cnt_q == HW'(LONG_CYCLES - 1)) begin
                        long_q  <= 1'b1;
                        state_q <= LONG;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                LONG: begin
                    if (!btn_level) begin
                        state_q       <= IDLE;
                        hold_active_q <= 1'b0;
                    end
                end
`ifdef DOUBLE_PRESS_EN
                WAIT_SECOND: begin
                    // A rise on the expiry cycle still counts as a double press.
                    if (btn_level) begin
                        double_q <= 1'b1;
                        state_q  <= SUPPRESS;
                    end else if (gap_cnt_q == GW'(DOUBLE_GAP_CYCLES - 1)) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                SUPPRESS: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q       <= IDLE;
                    hold_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_if.btn_level   = btn_level;
    assign btn_if.hold_active = hold_active_q;
    assign btn_if.short_press = short_q;
    assign btn_if.long_press  = long_q;
`ifdef DOUBLE_PRESS_EN
    assign btn_if.double_press = double_q;
`else
    assign btn_if.double_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier. Each scenario is a
// per-cycle raw-button / reset waveform; the reference model derives the
// expected output traces from the press rules (level follows the
// synchronized input once it has been stable for DEBOUNCE_CYCLES samples;
// presses are classified from their debounced high-run lengths).
module tb_button_press_classifier;

    localparam int D = 4;
    localparam int L = 20;
    localparam int G = 10;
    localparam int N = 256;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    button_press_classifier_if bif();

    button_press_classifier #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_CYCLES       (L),
        .DOUBLE_GAP_CYCLES (G)
    ) dut (
        .clk    (clk),
        .reset  (reset_n),
        .btn_if (bif)
    );

    bit    raw_a [N];
    bit    rst_a [N];
    int    len;
    logic  obs   [5][N];
    bit    ex    [5][N];
    int    total  = 0;
    int    passed = 0;
    string sig_name [5] = '{"btn_level", "hold_active", "short_press", "long_press", "double_press"};

    // ---------------- stimulus helpers ----------------
    task automatic clear_stim(input int n);
        len = n;
        for (int i = 0; i < N; i++) begin
            raw_a[i] = 1'b0;
            rst_a[i] = (i < 3);
        end
    endtask

    task automatic press(input int start, input int width);
        for (int i = start; i < start + width && i < len; i++) raw_a[i] = 1'b1;
    endtask

    // Drive one waveform entry per clock edge, sample 1 time unit after it.
    task automatic run_stim();
        for (int t = 0; t < len; t++) begin
            bif.btn_raw = raw_a[t];
            reset_n     = !rst_a[t];
            @(posedge clk);
            #1;
            obs[0][t] = bif.btn_level;
            obs[1][t] = bif.hold_active;
            obs[2][t] = bif.short_press;
            obs[3][t] = bif.long_press;
            obs[4][t] = bif.double_press;
        end
    endtask

    function automatic bit rst_in(input int a, input int b);
        for (int i = a; i <= b; i++)
            if (i >= 0 && i < len && rst_a[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int count_obs(input int k);
        int c;
        c = 0;
        for (int t = 0; t < len; t++) if (obs[k][t] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_obs(input int k, input int from);
        for (int t = from; t < len; t++) if (obs[k][t] === 1'b1) return t;
        return -1;
    endfunction

    // ---------------- reference model ----------------
    task automatic build_model();
        bit lvl [N];
        bit sa  [N];
        bit prev, stable, sup;
        int e, f, t;
`ifdef DOUBLE_PRESS_EN
        bit pend;
        int pf;
        pend = 1'b0;
        pf   = 0;
`endif
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < N; i++) ex[k][i] = 1'b0;
        // Synchronized sample visible after each edge (two-flop delay, cleared by reset).
        for (int i = 0; i < len; i++)
            sa[i] = (rst_a[i] || i == 0 || rst_a[i-1]) ? 1'b0 : raw_a[i-1];
        // Debounced level: flips once the last D synchronized samples all disagree with it.
        for (int i = 0; i < len; i++) begin
            if (rst_a[i]) begin
                lvl[i] = 1'b0;
            end else begin
                prev   = (i > 0) ? lvl[i-1] : 1'b0;
                stable = (i >= D);
                for (int j = i - D; j < i; j++)
                    if (j < 0 || sa[j] == prev) stable = 1'b0;
                lvl[i] = stable ? ~prev : prev;
            end
            ex[0][i] = lvl[i];
        end
        // Classify each debounced high run [e, f).
        t = 0;
        while (t < len) begin
            if (lvl[t] && (t == 0 || !lvl[t-1])) begin
                e = t;
                f = t;
                while (f < len && lvl[f]) f++;
                sup = 1'b0;
`ifdef DOUBLE_PRESS_EN
                if (pend) begin
                    pend = 1'b0;
                    if (e - pf - 1 <= G - 1) begin
                        if (!rst_in(pf, e + 1)) begin
                            if (e + 1 < len) ex[4][e+1] = 1'b1;
                            sup = 1'b1;
                        end
                    end else if (pf + 1 + G < len && !rst_in(pf, pf + 1 + G)) begin
                        ex[2][pf+1+G] = 1'b1;
                    end
                end
`endif
                if (!sup) begin
                    for (int i = e + 1; i <= f && i < len; i++) ex[1][i] = 1'b1;
                    if (f - e >= L) begin
                        if (e + L < len) ex[3][e+L] = 1'b1;
                    end else if (f < len && !rst_in(f, f + 1)) begin
`ifdef DOUBLE_PRESS_EN
                        pend = 1'b1;
                        pf   = f;
`else
                        if (f + 1 < len) ex[2][f+1] = 1'b1;
`endif
                    end
                end
                t = f;
            end else begin
                t++;
            end
        end
`ifdef DOUBLE_PRESS_EN
        if (pend && pf + 1 + G < len && !rst_in(pf, pf + 1 + G)) ex[2][pf+1+G] = 1'b1;
`endif
        for (int i = 0; i < len; i++)
            if (rst_a[i])
                for (int k = 0; k < 5; k++) ex[k][i] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_stim(8);
        for (int i = 0; i < 8; i++) raw_a[i] = 1'b1;
        for (int i = 0; i < 8; i++) rst_a[i] = 1'b1;
        run_stim();
        for (int k = 0; k < 5; k++) begin
            total++;
            if (obs[k][7] === 1'b0) passed++;
            else $display("FAIL reset %s: actual=%b required=0", sig_name[k], obs[k][7]);
        end
    endtask

    task automatic test_short();
        int r;
        clear_stim(60);
        press(5, 10);
        run_stim();
        build_model();
        for (int k = 0; k < 5; k++) begin
            int bad;
            bad = -1;
            for (int t = len - 1; t >= 0; t--) if (obs[k][t] !== logic'(ex[k][t])) bad = t;
            total++;
            if (bad < 0) passed++;
            else $display("FAIL short %s: cycle %0d actual=%b required=%b", sig_name[k], bad, obs[k][bad], ex[k][bad]);
        end
        r = first_obs(0, 0);
        total++;
        if (r == 4 + 2 + D) passed++;
        else $display("FAIL short level_rise: actual=%0d required=%0d", r, 4 + 2 + D);
        total++;
        if (count_obs(2) == 1 && count_obs(3) == 0) passed++;
        else $display("FAIL short pulse_count: actual short=%0d long=%0d required short=1 long=0", count_obs(2), count_obs(3));
    endtask

    task automatic test_bounce();
        clear_stim(40);
        press(5, 1);
        press(7, 1);
        run_stim();
        build_model();
        for (int k = 0; k < 5; k++) begin
            int bad;
            bad = -1;
            for (int t = len - 1; t >= 0; t--) if (obs[k][t] !== logic'(ex[k][t])) bad = t;
            total++;
            if (bad < 0) passed++;
            else $display("FAIL bounce %s: cycle %0d actual=%b required=%b", sig_name[k], bad, obs[k][bad], ex[k][bad]);
        end
        total++;
        if (count_obs(0) + count_obs(2) + count_obs(3) + count_obs(4) == 0) passed++;
        else $display("FAIL bounce activity: actual level/pulse cycles=%0d required=0", count_obs(0) + count_obs(2) + count_obs(3) + count_obs(4));
    endtask

    task automatic test_long();
        int rise, lp;
        clear_stim(90);
        press(5, 40);
        run_stim();
        build_model();
        for (int k = 0; k < 5; k++) begin
            int bad;
            bad = -1;
            for (int t = len - 1; t >= 0; t--) if (obs[k][t] !== logic'(ex[k][t])) bad = t;
            total++;
            if (bad < 0) passed++;
            else $display("FAIL long %s: cycle %0d actual=%b required=%b", sig_name[k], bad, obs[k][bad], ex[k][bad]);
        end
        rise = first_obs(0, 0);
        lp   = first_obs(3, 0);
        total++;
        if (rise >= 0 && lp - rise == L) passed++;
        else $display("FAIL long latency: actual=%0d required=%0d", lp - rise, L);
        total++;
        if (count_obs(3) == 1 && count_obs(2) == 0) passed++;
        else $display("FAIL long pulse_count: actual long=%0d short=%0d required long=1 short=0", count_obs(3), count_obs(2));
    endtask

    task automatic test_boundary();
        // Level high for L-1 cycles falls on the threshold cycle; L cycles reaches it.
        for (int w = L - 1; w <= L; w++) begin
            clear_stim(80);
            press(5, w);
            run_stim();
            build_model();
            for (int k = 0; k < 5; k++) begin
                int bad;
                bad = -1;
                for (int t = len - 1; t >= 0; t--) if (obs[k][t] !== logic'(ex[k][t])) bad = t;
                total++;
                if (bad < 0) passed++;
                else $display("FAIL boundary w=%0d %s: cycle %0d actual=%b required=%b", w, sig_name[k], bad, obs[k][bad], ex[k][bad]);
            end
            total++;
            if (count_obs(2) == ((w < L) ? 1 : 0) && count_obs(3) == ((w < L) ? 0 : 1)) passed++;
            else $display("FAIL boundary w=%0d pulses: actual short=%0d long=%0d", w, count_obs(2), count_obs(3));
        end
    endtask

    task automatic test_reset_mid_press();
        int rise, lp;
        clear_stim(100);
        press(5, 90);
        for (int i = 22; i <= 24; i++) rst_a[i] = 1'b1;
        run_stim();
        build_model();
        for (int k = 0; k < 5; k++) begin
            int bad;
            bad = -1;
            for (int t = len - 1; t >= 0; t--) if (obs[k][t] !== logic'(ex[k][t])) bad = t;
            total++;
            if (bad < 0) passed++;
            else $display("FAIL reset_mid %s: cycle %0d actual=%b required=%b", sig_name[k], bad, obs[k][bad], ex[k][bad]);
        end
        rise = first_obs(0, 25);
        lp   = first_obs(3, 0);
        total++;
        if (rise == 24 + 2 + D) passed++;
        else $display("FAIL reset_mid rerise: actual=%0d required=%0d", rise, 24 + 2 + D);
        total++;
        if (lp == 24 + 2 + D + L && count_obs(3) == 1) passed++;
        else $display("FAIL reset_mid long: actual cycle=%0d count=%0d required cycle=%0d", lp, count_obs(3), 24 + 2 + D + L);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int t, w, r;
            clear_stim(220);
            t = 5;
            while (t < 200) begin
                w = $urandom_range(1, 30);
                press(t, w);
                t = t + w + $urandom_range(1, 18);
            end
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(20, 190);
                rst_a[r]   = 1'b1;
                rst_a[r+1] = 1'b1;
            end
            run_stim();
            build_model();
            for (int k = 0; k < 5; k++) begin
                int bad;
                bad = -1;
                for (int c = len - 1; c >= 0; c--) if (obs[k][c] !== logic'(ex[k][c])) bad = c;
                total++;
                if (bad < 0) passed++;
                else $display("FAIL random#%0d %s: cycle %0d actual=%b required=%b", it, sig_name[k], bad, obs[k][bad], ex[k][bad]);
            end
        end
    endtask

`ifdef DOUBLE_PRESS_EN
    task automatic test_double_press();
        int fall, sp;
        for (int gap = 5; gap <= 15; gap += 10) begin
            clear_stim(90);
            press(5, 8);
            press(5 + 8 + gap, 8);
            run_stim();
            build_model();
            for (int k = 0; k < 5; k++) begin
                int bad;
                bad = -1;
                for (int t = len - 1; t >= 0; t--) if (obs[k][t] !== logic'(ex[k][t])) bad = t;
                total++;
                if (bad < 0) passed++;
                else $display("FAIL double gap=%0d %s: cycle %0d actual=%b required=%b", gap, sig_name[k], bad, obs[k][bad], ex[k][bad]);
            end
            if (gap < G) begin
                total++;
                if (count_obs(4) == 1 && count_obs(2) == 0) passed++;
                else $display("FAIL double gap=%0d pulses: actual double=%0d short=%0d required 1/0", gap, count_obs(4), count_obs(2));
            end else begin
                fall = -1;
                for (int t = 1; t < len && fall < 0; t++)
                    if (obs[0][t-1] === 1'b1 && obs[0][t] === 1'b0) fall = t;
                sp = first_obs(2, 0);
                total++;
                if (count_obs(2) == 2 && count_obs(4) == 0 && sp == fall + 1 + G) passed++;
                else $display("FAIL double gap=%0d shorts: actual count=%0d first=%0d required count=2 first=%0d", gap, count_obs(2), sp, fall + 1 + G);
            end
        end
    endtask
`endif

    initial begin
        bif.btn_raw = 1'b0;
        reset_n     = 1'b0;
        test_reset();
        test_short();
        test_bounce();
        test_long();
        test_boundary();
        test_reset_mid_press();
        test_random();
`ifdef DOUBLE_PRESS_EN
        test_double_press();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
